bp_cfg_dump: RTL
================

BP_CFG_DUMP -- requirements
Module: bp_cfg_dump

Interface
REQ-001 Parameter cfg_width_p, default 1024: width of the flattened processor-parameter vector to be read back.
REQ-002 Parameter word_width_p, default 32: width of one output beat; words_lp = ceil(cfg_width_p/word_width_p), which is 32 at defaults.
REQ-003 Parameter checksum_p, default 1: when 1, a checksum beat follows the data beats.
REQ-004 Derived widths: idx_width_lp = clog2(words_lp), which is 5 at defaults; cnt_width_lp = clog2(words_lp+1), which is 6 at defaults.
REQ-005 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n_i  input  1  synchronous, active-low reset.
REQ-007 cfg_i  input  cfg_width_p  flattened parameter vector; bit 0 is the LSB of word 0.
REQ-008 req_v_i  input  1  read request valid.
REQ-009 req_ready_o  output  1  request accepted when req_v_i & req_ready_o.
REQ-010 req_start_i  input  idx_width_lp  first word index.
REQ-011 req_count_i  input  cnt_width_lp  number of words to return.
REQ-012 data_o  output  word_width_p  response beat payload.
REQ-013 data_v_o  output  1  response beat valid.
REQ-014 data_ready_i  input  1  beat consumed when data_v_o & data_ready_i.
REQ-015 data_last_o  output  1  marks the final beat of a response.
REQ-016 err_o  output  1  qualifies the current beat as an error beat.
REQ-017 busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, SEND, CSUM and ERR.
REQ-019 req_ready_o SHALL be 1 only in IDLE; data_v_o SHALL be 1 only in SEND, CSUM and ERR.
REQ-020 On acceptance in IDLE, the block SHALL capture cfg_i into a snapshot register; later changes to cfg_i SHALL NOT affect the in-flight response.
REQ-021 On acceptance, the block SHALL load idx=req_start_i, rem=req_count_i and csum=0.
REQ-022 The request is illegal when req_count_i==0 or req_start_i+req_count_i>words_lp; the sum SHALL be computed at cnt_width_lp+1 bits with no wrap.
REQ-023 A legal request SHALL move the FSM to SEND; an illegal request SHALL move it to ERR.
REQ-024 First-beat latency: data_v_o SHALL assert in the cycle after acceptance.
REQ-025 In SEND, data_o SHALL equal snapshot word idx; bits at or above cfg_width_p SHALL read as 0.
REQ-026 On each SEND handshake: idx increments, rem decrements, and csum ^= data_o.
REQ-027 On the SEND handshake with rem==1, the FSM SHALL go to CSUM if checksum_p==1, otherwise to IDLE.
REQ-028 data_last_o SHALL be 1 in SEND only when rem==1 and checksum_p==0.
REQ-029 In CSUM, data_o SHALL equal csum and data_last_o SHALL be 1; the handshake returns the FSM to IDLE.
REQ-030 In ERR, data_o SHALL be 0 and err_o and data_last_o SHALL both be 1; the handshake returns the FSM to IDLE.
REQ-031 err_o SHALL be 0 outside ERR; data_o SHALL be 0 in IDLE.
REQ-032 While data_v_o=1 and data_ready_i=0, data_o, data_last_o, err_o and all state SHALL hold unchanged; the block SHALL never retract data_v_o.
REQ-033 req_v_i SHALL be ignored while busy; the earliest next acceptance is the cycle after the final handshake, so there are no back-to-back overlapping responses.
REQ-034 Per-beat throughput SHALL be one beat per cycle with data_ready_i held at 1.
REQ-035 A request covering the last word (idx reaches words_lp-1) SHALL terminate without idx wrap-around.

Reset
REQ-036 When reset_n_i==0 at a rising edge, the FSM SHALL enter IDLE and idx, rem, csum and the snapshot SHALL clear to 0.
REQ-037 During reset the outputs SHALL be req_ready_o=0, data_v_o=0, data_last_o=0, err_o=0, busy_o=0 and data_o=0.
REQ-038 req_ready_o SHALL rise in the first cycle after reset_n_i returns to 1.
REQ-039 Reset asserted mid-response SHALL abort the response immediately, with no last beat emitted.

Verification
REQ-040 Defaults, cfg_i word k = 32'hA000_0000+k, request start=3, count=2, ready held 1 -> beats A0000003, A0000004, then checksum 00000007 with last=1, err=0; 3 beats total, first beat 1 cycle after acceptance.
REQ-041 Request start=31, count=1 -> beat A000001F, then checksum A000001F with last=1; request start=31, count=2 -> single beat data=0, err=1, last=1.
REQ-042 Request count=0 -> single error beat; immediately after, request start=0, count=32 -> 32 data beats plus checksum equal to XOR of all 32 words.
REQ-043 Randomized data_ready_i backpressure, with cfg_i changed every cycle after acceptance -> payload matches the snapshot, outputs stable while stalled, and req_ready_o=0 throughout.
REQ-044 checksum_p=0, cfg_width_p=80, word_width_p=32, start=2, count=1 -> beat equals cfg_i[79:64] zero-extended, with last=1.
REQ-045 reset_n_i=0 during beat 2 of a 4-beat response -> data_v_o=0 in the same cycle; after release, idle with req_ready_o=1 and a new request served correctly.

Source files
------------

// File: rtl/bp_cfg_dump.sv
// Read-back engine for a flattened processor-parameter vector: returns a window of words
// from a snapshot taken at request time, optionally followed by an XOR checksum beat.
module bp_cfg_dump #(
  parameter int cfg_width_p  = 1024,
  parameter int word_width_p = 32,
  parameter int checksum_p   = 1,
  localparam int words_lp     = (cfg_width_p + word_width_p - 1) / word_width_p,
  localparam int idx_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1,
  localparam int cnt_width_lp = $clog2(words_lp + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cfg_width_p-1:0]  cfg_i,
  input  logic                    req_v_i,
  output logic                    req_ready_o,
  input  logic [idx_width_lp-1:0] req_start_i,
  input  logic [cnt_width_lp-1:0] req_count_i,
  output logic [word_width_p-1:0] data_o,
  output logic                    data_v_o,
  input  logic                    data_ready_i,
  output logic                    data_last_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int pad_width_lp = words_lp * word_width_p;
  localparam bit csum_en_lp   = (checksum_p != 0);

  typedef enum logic [1:0] {IDLE, SEND, CSUM, ERR} state_t;

  state_t                    state_q, state_d;
  logic [idx_width_lp-1:0]   idx_q, idx_d;
  logic [cnt_width_lp-1:0]   rem_q, rem_d;
  logic [word_width_p-1:0]   csum_q, csum_d;
  logic [pad_width_lp-1:0]   snap_q, snap_d;

  logic [pad_width_lp-1:0]   cfg_pad;
  logic [word_width_p-1:0]   snap_words [words_lp];
  logic [word_width_p-1:0]   cur_word;
  logic [cnt_width_lp:0]     req_end;
  logic                      req_bad;

  logic [word_width_p-1:0]   data_n;
  logic                      data_v_n, last_n, err_n, ready_n;

  // Bits above cfg_width_p in the last word are padded with zeros.
  always_comb begin
    cfg_pad = '0;
    cfg_pad[cfg_width_p-1:0] = cfg_i;
  end

  for (genvar gi = 0; gi < words_lp; gi++) begin : g_words
    assign snap_words[gi] = snap_q[gi*word_width_p +: word_width_p];
  end

  assign cur_word = snap_words[idx_q];

  // One extra bit so start+count never wraps before the range check.
  assign req_end = (cnt_width_lp+1)'(req_start_i) + (cnt_width_lp+1)'(req_count_i);
  assign req_bad = (req_count_i == '0) || (req_end > (cnt_width_lp+1)'(words_lp));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    snap_d   = snap_q;
    data_n   = '0;
    data_v_n = 1'b0;
    last_n   = 1'b0;
    err_n    = 1'b0;
    ready_n  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_n = 1'b1;
        if (req_v_i) begin
          snap_d  = cfg_pad;
          idx_d   = req_start_i;
          rem_d   = req_count_i;
          csum_d  = '0;
          state_d = req_bad ? ERR : SEND;
        end
      end
      SEND: begin
        data_v_n = 1'b1;
        data_n   = cur_word;
        last_n   = (rem_q == cnt_width_lp'(1)) && !csum_en_lp;
        if (data_ready_i) begin
          idx_d  = idx_q + idx_width_lp'(1);
          rem_d  = rem_q - cnt_width_lp'(1);
          csum_d = csum_q ^ cur_word;
          if (rem_q == cnt_width_lp'(1)) begin
            state_d = csum_en_lp ? CSUM : IDLE;
          end
        end
      end
      CSUM: begin
        data_v_n = 1'b1;
        data_n   = csum_q;
        last_n   = 1'b1;
        if (data_ready_i) state_d = IDLE;
      end
      ERR: begin
        data_v_n = 1'b1;
        last_n   = 1'b1;
        err_n    = 1'b1;
        if (data_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      snap_q  <= snap_d;
    end
  end

  // Reset masks the outputs combinationally so an aborted beat vanishes in the same cycle.
  assign req_ready_o = ready_n & reset_n_i;
  assign data_v_o    = data_v_n & reset_n_i;
  assign data_last_o = last_n & reset_n_i;
  assign err_o       = err_n & reset_n_i;
  assign data_o      = reset_n_i ? data_n : '0;
  assign busy_o      = (state_q != IDLE) & reset_n_i;

endmodule
